// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring radix-2 divider for DIV/DIVU issued from
//            the EX stage. It produces one quotient bit per cycle and holds
//            the pipeline with a stall request while a division is running.
//            The operation is abandoned if the issuing instruction is flushed.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous reset, active low
//            start      - EX holds a DIV/DIVU (held while stall is high)
//            signed_div - 1 = DIV (two's complement), 0 = DIVU
//            opa, opb   - dividend (rs) and divisor (rt)
//            annul      - flush of the issuing instruction
//            stall      - pipeline hold request (combinational)
//            ready      - one-cycle pulse, result valid
//            result     - {remainder (HI), quotient (LO)}
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       prem_q, prem_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0]     dvd_q, dvd_d;        // dividend in, quotient bits shift in at LSB
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic                 qbit;
  logic [WIDTH:0]       step_rem;
  logic [WIDTH-1:0]     step_dvd;
  logic [WIDTH-1:0]     opa_mag;
  logic [WIDTH-1:0]     opb_mag;

  // One restoring step: subtract the divisor from the shifted partial
  // remainder; a clear guard bit means the subtraction did not underflow.
  always_comb begin
    shifted  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, divisor_q};
    qbit     = ~trial[WIDTH];
    step_rem = qbit ? trial : shifted;
    step_dvd = {dvd_q[WIDTH-2:0], qbit};
    // Unsigned magnitude: the most negative value maps onto itself, which
    // is the correct unsigned magnitude.
    opa_mag  = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    opb_mag  = (signed_div && opb[WIDTH-1]) ? -opb : opb;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    ready_d   = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          qneg_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          rneg_d = signed_div & opa[WIDTH-1];
          if (opb == '0) begin
            // Divide by zero bypasses the datapath and the sign fix.
            result_d = {opa, {WIDTH{1'b1}}};
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            prem_d    = '0;
            dvd_d     = opa_mag;
            divisor_d = opb_mag;
            cnt_d     = '0;
            state_d   = BUSY;
          end
        end
      end

      BUSY: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          prem_d = step_rem;
          dvd_d  = step_dvd;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Final step: apply the sign fix while writing the result.
            result_d = {(rneg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0]),
                        (qneg_q ? -step_dvd : step_dvd)};
            ready_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  // Low in DONE so the instruction advances in the same cycle as ready.
  assign stall  = rst & (((state_q == IDLE) & start & ~annul) | (state_q == BUSY));
  assign ready  = ready_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit. Expected results come from a
//            64-bit arithmetic reference of MIPS DIV/DIVU semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          signed_div = 1'b0;
  logic          annul = 1'b0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          stall;
  logic          ready;
  logic [2*W-1:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall      (stall),
    .ready      (ready),
    .result     (result)
  );

  // Reference: truncating division in 64-bit arithmetic, wrapped to W bits.
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one divide and waits (bounded) for ready. Leaves start high at
  // the negedge where ready was seen (DONE cycle); callers drop it.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output logic got, output int lat, output int stall_n,
                        output logic [63:0] res);
    got = 1'b0; lat = 0; stall_n = 0; res = '0;
    @(negedge clk);
    start = 1'b1; signed_div = sd; opa = a; opb = b;
    for (int c = 1; c <= 60 && !got; c++) begin
      #1;
      if (stall === 1'b1) stall_n++;
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1'b1; lat = c; res = result;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; opa = 32'd5; opb = 32'd1;
    @(negedge clk); @(negedge clk);
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests_run++;
    if (result !== 64'd0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", result); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic got; int lat, sn; logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, got, lat, sn, res);
    tests_run++;
    if (got !== 1'b1 || lat != 33) begin tests_failed++; $display("FAIL divu_latency: got ready=%b at %0d expected 33", got, lat); end
    tests_run++;
    if (sn != 33) begin tests_failed++; $display("FAIL divu_stall_cycles: got %0d expected 33", sn); end
    tests_run++;
    if (res !== 64'h0000_0002_0000_000E) begin tests_failed++; $display("FAIL divu_result: got %h expected 000000020000000e", res); end
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL done_stall: got %b expected 0", stall); end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL ready_pulse: got %b expected 0", ready); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (result !== 64'h0000_0002_0000_000E) begin tests_failed++; $display("FAIL result_hold: got %h expected 000000020000000e", result); end
  endtask

  task automatic test_signed();
    logic [96:0] cases [4];
    logic got; int lat, sn; logic [63:0] res;
    logic [96:0] cs;
    cases[0] = {1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    cases[1] = {1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
    cases[2] = {1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    cases[3] = {1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] qexp;
      cs = cases[i];
      qexp = (i == 0 || i == 1) ? 32'hFFFF_FFFD : (i == 2) ? 32'h8000_0000 : 32'h0FFF_FFFF;
      do_div(cs[96], cs[95:64], cs[63:32], got, lat, sn, res);
      start = 1'b0;
      tests_run++;
      if (got !== 1'b1 || res !== {cs[31:0], qexp})
        begin tests_failed++; $display("FAIL signed_case%0d: got %h expected %h", i, res, {cs[31:0], qexp}); end
    end
  endtask

  task automatic test_div_zero();
    logic got; int lat, sn; logic [63:0] res;
    do_div(1'b1, 32'h0000_1234, 32'd0, got, lat, sn, res);
    start = 1'b0;
    tests_run++;
    if (got !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL dz_latency: got ready=%b at %0d expected 1", got, lat); end
    tests_run++;
    if (sn != 1) begin tests_failed++; $display("FAIL dz_stall_cycles: got %0d expected 1", sn); end
    tests_run++;
    if (res !== 64'h0000_1234_FFFF_FFFF) begin tests_failed++; $display("FAIL dz_result: got %h expected 00001234ffffffff", res); end
  endtask

  task automatic test_annul();
    logic got; int lat, sn, pulses; logic [63:0] res, prior;
    prior = result;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL annul_stall: got %b expected 0", stall); end
    tests_run++;
    if (result !== prior) begin tests_failed++; $display("FAIL annul_result: got %h expected %h", result, prior); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin tests_failed++; $display("FAIL annul_no_ready: got %0d pulses expected 0", pulses); end
    do_div(1'b0, 32'd9, 32'd3, got, lat, sn, res);
    start = 1'b0;
    tests_run++;
    if (got !== 1'b1 || lat != 33 || res !== 64'h0000_0000_0000_0003)
      begin tests_failed++; $display("FAIL after_annul: got %h at %0d expected 0000000000000003 at 33", res, lat); end
  endtask

  task automatic test_collision();
    int pulses; logic [63:0] prior;
    prior = result;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; opa = 32'd50; opb = 32'd5;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL collision_stall: got %b expected 0", stall); end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL collision_idle: got stall %b expected 0", stall); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0 || result !== prior)
      begin tests_failed++; $display("FAIL collision_no_op: got %0d pulses result %h expected 0 pulses %h", pulses, result, prior); end
  endtask

  task automatic test_reset_mid();
    logic got; int lat, sn; logic [63:0] res;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd5000; opb = 32'd7;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stall_comb: got %b expected 0", stall); end
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0)
      begin tests_failed++; $display("FAIL rstmid_state: got ready=%b result=%h stall=%b expected 0/0/0", ready, result, stall); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd12345, 32'd67, got, lat, sn, res);
    start = 1'b0;
    tests_run++;
    if (got !== 1'b1 || lat != 33 || res !== ref_div(1'b0, 32'd12345, 32'd67))
      begin tests_failed++; $display("FAIL after_rst: got %h at %0d expected %h at 33", res, lat, ref_div(1'b0, 32'd12345, 32'd67)); end
  endtask

  task automatic test_random();
    logic got; int lat, sn; logic [63:0] res, exp;
    logic sd; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = a;
        4:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      exp = ref_div(sd, a, b);
      do_div(sd, a, b, got, lat, sn, res);
      start = 1'b0;
      tests_run++;
      if (got !== 1'b1 || res !== exp)
        begin tests_failed++; $display("FAIL rand%0d sd=%b %h/%h: got %h expected %h", i, sd, a, b, res, exp); end
      tests_run++;
      if (lat != ((b == 32'd0) ? 1 : 33) || sn != lat)
        begin tests_failed++; $display("FAIL rand%0d_timing: got lat %0d stall %0d expected %0d", i, lat, sn, (b == 32'd0) ? 1 : 33); end
    end
  endtask

  task automatic test_back_to_back();
    logic got; int lat, sn; logic [63:0] res;
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, got, lat, sn, res);
    // start stays high through DONE with new operands; it must be ignored.
    signed_div = 1'b1; opa = 32'hFFFF_FF9C; opb = 32'd7;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_stall: got %b expected 0", stall); end
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, got, lat, sn, res);
    start = 1'b0;
    tests_run++;
    if (got !== 1'b1 || lat != 33 || sn != 33)
      begin tests_failed++; $display("FAIL b2b_timing: got lat %0d stall %0d expected 33/33", lat, sn); end
    tests_run++;
    if (res !== 64'hFFFF_FFFE_FFFF_FFF2)
      begin tests_failed++; $display("FAIL b2b_result: got %h expected fffffffefffffff2", res); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_collision();
    test_reset_mid();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle divider and its sequencing controller for the MIPS pipeline. It executes DIV/DIVU issued from the EX stage and holds the pipeline with a stall request while the division runs. It returns a 64-bit {remainder, quotient} result for the HI/LO write and abandons the operation when the issuing instruction is flushed. Division is restoring, radix-2, one quotient bit per cycle.

## Interface
- `WIDTH`, default 32: operand width; the result is 2*WIDTH bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  EX holds a DIV/DIVU; held high by EX while `stall` is high.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `opa`  in  WIDTH  dividend (rs); sampled with `start`.
- `opb`  in  WIDTH  divisor (rt); sampled with `start`.
- `annul`  in  1  flush of the issuing instruction (exception or branch squash).
- `stall`  out  1  pipeline hold request to the hazard unit.
- `ready`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO).

## Operation
- The state machine has three states: IDLE, BUSY, DONE. A 5-bit step counter `cnt` is used for WIDTH=32; in general it is clog2(WIDTH) bits.
- IDLE:
  - If `start && !annul`, latch `|opa|` and `|opb|`. Absolute values are taken only when `signed_div`. Unsigned magnitude is used, so 0x8000_0000 stays 0x8000_0000.
  - Also latch `qneg = signed_div & (opa[W-1]^opb[W-1])` and `rneg = signed_div & opa[W-1]`.
  - If `opb == 0`, go to DONE with quotient = all-ones and remainder = `opa` unmodified.
  - Otherwise clear the partial remainder (W+1 bits), load the dividend shift register, set `cnt = 0`, and go to BUSY.
- BUSY, one step per cycle:
  - Compute `trial = {prem[W-1:0], dvd[W-1]} - {1'b0, divisor}`.
  - If `trial` is non-negative, `prem = trial` and shift in quotient bit 1. Otherwise shift `{prem, dvd[W-1]}` and shift in quotient bit 0.
  - The dividend shifts left by 1 and `cnt` increments.
  - After the step with `cnt == W-1`, go to DONE.
- Sign fix on entry to DONE: the quotient is negated if `qneg`, and the remainder is negated if `rneg`. All arithmetic wraps modulo 2^W, so 0x8000_0000 / 0xFFFF_FFFF (signed) gives quotient 0x8000_0000 and remainder 0.
- DONE: `ready = 1` for exactly this cycle, then an unconditional return to IDLE. `start` is ignored in DONE.
- `result` is a register. It is written only on entry to DONE and holds its value until the next completion.
- `stall = rst & ((state==IDLE & start & !annul) | state==BUSY)`. `stall` is combinational, and it is 0 in DONE so the instruction advances while `ready` is high.
- `annul` handling:
  - `annul` in BUSY forces IDLE on the next edge. There is no `ready` pulse, and `result` is unchanged.
  - `annul` in IDLE blocks a start.
  - `annul` in DONE has no effect; the HI/LO write is gated downstream.
- Simultaneous events: `annul` has priority over `start`, and `rst` has priority over everything.

## Timing
- Reset (`rst` low at an edge) gives state IDLE, `cnt` = 0, `result` = 0, and `ready` = 0. `stall` is 0 while `rst` is low.
- Normal divide, with `start` first seen in IDLE at cycle 0:
  - Cycles 1..W (1..32) are BUSY.
  - Cycle W+1 (33) is DONE, with `ready` = 1 and `result` valid.
  - `stall` is high for cycles 0..32, which is 33 cycles.
- Divide by zero: `start` at cycle 0, DONE and `ready` at cycle 1, `stall` high for cycle 0 only.
- Back-to-back divides: a new `start` is accepted in the IDLE cycle after DONE at the earliest. The minimum spacing is W+2 cycles.
- Reset mid-operation aborts immediately. No `ready` pulse is produced, and `result` reads 0.

## Test plan
- Unsigned divide: DIVU 100 / 7 gives `stall` high for 33 cycles, then `ready` at cycle 33 with `result` = {0x0000_0002, 0x0000_000E}. `result` holds afterwards.
- Signed sign combinations:
  - DIV -7 / 2 gives {0xFFFF_FFFF, 0xFFFF_FFFD}.
  - DIV 7 / -2 gives {0x0000_0001, 0xFFFF_FFFD}.
  - DIV 0x8000_0000 / 0xFFFF_FFFF gives {0, 0x8000_0000}.
  - DIVU 0xFFFF_FFFF / 0x10 gives {0xF, 0x0FFF_FFFF}.
- Divide by zero: DIV 0x1234 / 0 gives `ready` at cycle 1 with {0x0000_1234, 0xFFFF_FFFF}, and `stall` high for exactly 1 cycle.
- Annul mid-divide: pulse `annul` at cycle 10 of BUSY. Expect IDLE at cycle 11, `stall` low, no `ready`, and `result` still holding the prior value. A new DIVU 9 / 3 then completes with {0, 3} after 33 cycles.
- Start/annul collision: `start` and `annul` high together in IDLE give `stall` 0 and no state change.
- Reset mid-operation: `rst` low at BUSY cycle 20 gives `ready` 0, `result` 0, and `stall` 0. After `rst` goes high, the next divide completes normally.
